// File: rtl/display_refresh_ctrl.sv
// Per-frame RTC scan sequencer: reads ten RTC registers into a staging buffer and
// commits them to the text generator atomically on a vertical-blank tick.
module display_refresh_ctrl #(
  parameter int ACK_TIMEOUT  = 64,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  output logic        rd_req,
  output logic [3:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [71:0] disp_digits,
  output logic        am_pm,
  output logic        ring_on_blink,
  output logic        scan_err
);

  localparam int            TW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0]    LAST_ADDR  = 4'd9;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [3:0]    addr_nxt;
  logic          err_set;
  logic          commit;
  logic          stage_wr;

  logic [71:0]   stage_digits;
  logic [1:0]    stage_status;
  logic          alarm_q;

  logic [7:0]    blink_cnt, blink_cnt_nxt;
  logic          blink_ph, blink_ph_nxt;
  logic          alarm_nxt;

  // Scan sequencer: next state, address and ack-timeout bookkeeping
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    addr_nxt    = rd_addr;
    err_set     = 1'b0;
    commit      = 1'b0;
    stage_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_nxt   = REQ;
          addr_nxt    = 4'd0;
          tmo_cnt_nxt = '0;
        end
      end
      REQ: begin
        if (rd_ack) begin
          stage_wr  = 1'b1;
          state_nxt = (rd_addr == LAST_ADDR) ? DONE : GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          // Abandon the scan; the partial staging is never committed.
          err_set     = 1'b1;
          state_nxt   = IDLE;
          tmo_cnt_nxt = '0;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end
      GAP: begin
        state_nxt   = REQ;
        addr_nxt    = rd_addr + 4'd1;
        tmo_cnt_nxt = '0;
      end
      DONE: begin
        if (frame_tick) begin
          commit      = 1'b1;
          state_nxt   = REQ;
          addr_nxt    = 4'd0;
          tmo_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Blink phase advances on every frame tick regardless of scan progress
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_ph_nxt  = blink_ph;
    if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = 8'd0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + 8'd1;
      end
    end
    alarm_nxt = commit ? stage_status[1] : alarm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      rd_addr   <= 4'd0;
      rd_req    <= 1'b0;
      scan_err  <= 1'b0;
      blink_cnt <= 8'd0;
      blink_ph  <= 1'b1;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      rd_addr   <= addr_nxt;
      rd_req    <= (state_nxt == REQ);
      blink_cnt <= blink_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
      if (err_set)
        scan_err <= 1'b1;
      else if (commit)
        scan_err <= 1'b0;
    end
  end

  // Staging buffer: pure data, rewritten in full by every completed scan
  always_ff @(posedge clk) begin
    if (stage_wr) begin
      if (rd_addr == LAST_ADDR)
        stage_status <= rd_data[1:0];
      for (int k = 0; k < 9; k++)
        if (rd_addr == 4'(k))
          stage_digits[71-8*k -: 8] <= rd_data;
    end
  end

  // Committed display state, updated only by the DONE-state tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_digits   <= 72'd0;
      am_pm         <= 1'b0;
      alarm_q       <= 1'b0;
      ring_on_blink <= 1'b0;
    end else begin
      if (commit) begin
        disp_digits <= stage_digits;
        am_pm       <= stage_status[0];
      end
      alarm_q       <= alarm_nxt;
      ring_on_blink <= alarm_nxt & blink_ph_nxt;
    end
  end

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Scoreboard bench for display_refresh_ctrl: an RTC responder serves scans while a
// reference model predicts committed outputs after every frame tick.
module tb_display_refresh_ctrl;

  localparam int ACK_TIMEOUT  = 16;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic        rd_ack = 1'b0;
  logic [7:0]  rd_data = 8'd0;
  logic [71:0] disp_digits;
  logic        am_pm;
  logic        ring_on_blink;
  logic        scan_err;

  display_refresh_ctrl #(
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .disp_digits   (disp_digits),
    .am_pm         (am_pm),
    .ring_on_blink (ring_on_blink),
    .scan_err      (scan_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] digits;
    logic        ampm;
    logic        ring;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  rtc [10];

  logic [71:0] m_digits, st_digits;
  logic        m_ampm, m_alarm, m_err, m_phase;
  logic        st_ampm, st_alarm;
  int          m_bcnt;
  bit          m_scan_done;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digits    = 72'd0;
    m_ampm      = 1'b0;
    m_alarm     = 1'b0;
    m_err       = 1'b0;
    m_phase     = 1'b1;
    m_bcnt      = 0;
    m_scan_done = 1'b0;
  endtask

  task automatic model_tick();
    if (m_bcnt == BLINK_FRAMES - 1) begin
      m_bcnt  = 0;
      m_phase = ~m_phase;
    end else begin
      m_bcnt++;
    end
    if (m_scan_done) begin
      m_digits    = st_digits;
      m_ampm      = st_ampm;
      m_alarm     = st_alarm;
      m_err       = 1'b0;
      m_scan_done = 1'b0;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.digits = m_digits;
    e.ampm   = m_ampm;
    e.ring   = m_alarm & m_phase;
    e.err    = m_err;
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got no expectation, expected one queued");
    end else begin
      e = exp_q.pop_front();
      check("digits", disp_digits, e.digits);
      check("am_pm", am_pm, e.ampm);
      check("ring", ring_on_blink, e.ring);
      check("scan_err", scan_err, e.err);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick();
    push_expected();
    compare_outputs();
  endtask

  task automatic load_rtc(input logic [7:0] base, input logic [7:0] status);
    for (int k = 0; k < 9; k++) rtc[k] = base + 8'(k);
    rtc[9] = status;
  endtask

  // Serve one scan as the RTC; stops (rd_req still high) when reaching stop_at.
  task automatic serve_scan(input int max_d, input int tick_at, input int stop_at);
    for (int a = 0; a < 10; a++) begin
      bit stable;
      int d;
      check("req_up", rd_req, 1);
      check("addr", rd_addr, a);
      if (a == stop_at) return;
      stable = 1'b1;
      if (a == tick_at) begin
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick();
        push_expected();
        compare_outputs();
        stable = stable && (rd_req === 1'b1) && (rd_addr === 4'(a));
      end
      d = int'($urandom_range(max_d, 0));
      repeat (d) begin
        @(negedge clk);
        stable = stable && (rd_req === 1'b1) && (rd_addr === 4'(a));
      end
      check("req_stable", stable, 1);
      rd_ack  = 1'b1;
      rd_data = rtc[a];
      if (a < 9) st_digits[71-8*a -: 8] = rtc[a];
      else begin
        st_ampm  = rtc[9][0];
        st_alarm = rtc[9][1];
      end
      @(negedge clk);
      rd_ack  = 1'b0;
      rd_data = 8'($urandom);
      check("req_drop", rd_req, 0);
      if (a < 9) @(negedge clk);
    end
    m_scan_done = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    st_digits = 72'd0;
    st_ampm   = 1'b0;
    st_alarm  = 1'b0;
    load_rtc(8'h10, 8'h03);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", rd_req, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_digits", disp_digits, 0);
    check("rst_ampm", am_pm, 0);
    check("rst_ring", ring_on_blink, 0);
    check("rst_err", scan_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // stray ack while idle must not start anything
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("idle_ack_req", rd_req, 0);
    @(negedge clk);
    check("idle_ack_req2", rd_req, 0);

    // first scan, zero-wait; outputs hold until the DONE tick
    tick();
    serve_scan(0, -1, -1);
    push_expected();
    compare_outputs();
    repeat (3) begin
      @(negedge clk);
      check("done_wait", rd_req, 0);
    end
    tick();
    check("day_byte", disp_digits[71:64], 8'h10);
    check("tsec_byte", disp_digits[7:0], 8'h18);
    check("pm_bit", am_pm, 1);

    // new data, tick lands mid-scan and must not commit
    load_rtc(8'h20, 8'h01);
    serve_scan(0, 4, -1);
    tick();
    check("hour_byte", disp_digits[47:40], 8'h23);

    // timeout at address 4
    load_rtc(8'h30, 8'h02);
    serve_scan(0, -1, 4);
    n = 0;
    while (rd_req === 1'b1 && n < ACK_TIMEOUT + 4) begin
      @(negedge clk);
      n++;
    end
    check("tmo_len", n, ACK_TIMEOUT);
    check("tmo_req", rd_req, 0);
    m_err = 1'b1;
    push_expected();
    compare_outputs();
    repeat (4) begin
      @(negedge clk);
      check("tmo_idle", rd_req, 0);
    end
    tick();
    serve_scan(10, -1, -1);
    push_expected();
    compare_outputs();
    tick();
    check("err_clear", scan_err, 0);

    // blink with alarm set, then alarm cleared
    for (int i = 0; i < 6; i++) begin
      serve_scan(2, -1, -1);
      tick();
    end
    rtc[9] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      serve_scan(1, -1, -1);
      tick();
    end

    // asynchronous reset mid-scan at address 6
    serve_scan(0, -1, 6);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_req", rd_req, 0);
    check("arst_addr", rd_addr, 0);
    check("arst_digits", disp_digits, 0);
    check("arst_ampm", am_pm, 0);
    check("arst_ring", ring_on_blink, 0);
    check("arst_err", scan_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", rd_req, 0);
    end
    load_rtc(8'h40, 8'h03);
    tick();
    serve_scan(3, -1, -1);
    tick();
    check("final_min_byte", disp_digits[39:32], 8'h44);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
